// File: rtl/bcd_parity_up_counter.sv
// bcd_parity_up_counter: two-digit even/odd BCD up-counter with active-low seven-segment outputs.
// Define TERMINAL_STOP_EN to hold at 98/99 instead of wrapping to the sequence start.
module bcd_parity_up_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       odd,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       wrap
);
    localparam int DW = $clog2(TICK_DIV);
    logic [DW-1:0] div;
    logic          tick, match, carry, tens_top, load_ok, step;
    logic [4:0]    sum;
    logic [3:0]    units_nx, tens_nx;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction
    // a parity mismatch steps by one, which lands the value back on the mode's parity
    always_comb begin
        tick     = div == DW'(TICK_DIV - 1);
        match    = bcd0[0] == odd;
        sum      = {1'b0, bcd0} + (match ? 5'd2 : 5'd1);
        carry    = sum > 5'd9;
        units_nx = carry ? 4'(sum - 5'd10) : sum[3:0];
        tens_top = carry && bcd1 == 4'd9;
        tens_nx  = tens_top ? 4'd0 : bcd1 + 4'(carry);
        load_ok  = load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9;
`ifdef TERMINAL_STOP_EN
        step     = tick && enable && !load && !tens_top;
`else
        step     = tick && enable && !load;
`endif
    end
    // an invalid load still blocks the step: the value holds that cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            div  <= '0;
            bcd0 <= 4'd0;
            bcd1 <= 4'd0;
            wrap <= 1'b0;
        end else begin
            div  <= tick ? '0 : div + DW'(1);
            wrap <= step && tens_top;
            if (load && load_ok) begin
                bcd1 <= load_val[7:4];
                bcd0 <= load_val[3:0];
            end else if (step) begin
                bcd1 <= tens_nx;
                bcd0 <= units_nx;
            end
        end
    end
    assign hex0 = seg7(bcd0);
    assign hex1 = seg7(bcd1);
endmodule

// File: tb/tb_bcd_parity_up_counter.sv
// tb_bcd_parity_up_counter: per-cycle vector table with a scoreboard of expected count, wrap and segments.
module tb_bcd_parity_up_counter;
    localparam int TD = 4;
    logic       clock = 1'b0;
    logic       reset, enable, odd, load, wrap;
    logic [7:0] load_val;
    logic [3:0] bcd0, bcd1;
    logic [6:0] hex0, hex1;
    int         checks = 0;
    int         failures = 0;
    typedef struct {
        logic       rst, en, od, ld;
        logic [7:0] lv;
        logic [7:0] val;
        logic       w;
    } vec_t;
    typedef struct {
        logic [7:0] val;
        logic       w;
    } exp_t;
    vec_t vecs[$];
    exp_t sb[$];
    logic [6:0] seg[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_parity_up_counter #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .odd(odd), .load(load),
        .load_val(load_val), .bcd0(bcd0), .bcd1(bcd1), .hex0(hex0), .hex1(hex1), .wrap(wrap)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst, en, od, ld, input logic [7:0] lv, val, input logic w, input int n);
        vec_t t;
        t = '{rst, en, od, ld, lv, val, w};
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        int   v;
        // reset, then the even count from 00 with a step every 4th edge
        add(1, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            v = 2 * (k / 4);
            add(0, 1, 0, 0, 8'h00, 8'((v / 10) * 16 + v % 10), 0, 1);
        end
        // odd mode from 97: 99, then wrap to 01
        add(0, 1, 1, 1, 8'h97, 8'h97, 0, 1);
        add(0, 1, 1, 0, 8'h00, 8'h97, 0, 2);
        add(0, 1, 1, 0, 8'h00, 8'h99, 0, 4);
        add(0, 1, 1, 0, 8'h00, 8'h01, 1, 1);
        add(0, 1, 1, 0, 8'h00, 8'h01, 0, 1);
        // even mode from 45: realign to 46, then 48
        add(0, 1, 0, 1, 8'h45, 8'h45, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h45, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h46, 0, 4);
        add(0, 1, 0, 0, 8'h00, 8'h48, 0, 1);
        // invalid load, load during tick, enable low for 8 ticks
        add(0, 1, 0, 1, 8'h3A, 8'h48, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h48, 0, 2);
        add(0, 1, 0, 1, 8'h20, 8'h20, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h20, 0, 3);
        add(0, 0, 0, 0, 8'h00, 8'h20, 0, 8 * TD);
        add(0, 1, 0, 0, 8'h00, 8'h22, 0, 1);
        // reach 26 with div = 2, reset, then prescaler restarts from 0
        add(0, 1, 0, 0, 8'h00, 8'h22, 0, 3);
        add(0, 1, 0, 0, 8'h00, 8'h24, 0, 4);
        add(0, 1, 0, 0, 8'h00, 8'h26, 0, 3);
        add(1, 1, 0, 0, 8'h00, 8'h00, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h00, 0, 3);
        add(0, 1, 0, 0, 8'h00, 8'h02, 0, 1);
        // even mode from 96 across the tens overflow
        add(0, 1, 0, 1, 8'h96, 8'h96, 0, 1);
        add(0, 1, 0, 0, 8'h00, 8'h96, 0, 2);
        add(0, 1, 0, 0, 8'h00, 8'h98, 0, 4);
`ifdef TERMINAL_STOP_EN
        add(0, 1, 0, 0, 8'h00, 8'h98, 0, 6);
`else
        add(0, 1, 0, 0, 8'h00, 8'h00, 1, 1);
        add(0, 1, 0, 0, 8'h00, 8'h00, 0, 3);
        add(0, 1, 0, 0, 8'h00, 8'h02, 0, 2);
`endif
        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            enable   = vecs[i].en;
            odd      = vecs[i].od;
            load     = vecs[i].ld;
            load_val = vecs[i].lv;
            sb.push_back('{vecs[i].val, vecs[i].w});
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk("count", i, {bcd1, bcd0}, e.val);
            chk("wrap", i, {7'd0, wrap}, {7'd0, e.w});
            chk("hex0", i, {1'b0, hex0}, {1'b0, seg[e.val[3:0]]});
            chk("hex1", i, {1'b0, hex1}, {1'b0, seg[e.val[7:4]]});
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
